// File: rtl/regs_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package regs_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Arbiter FSM states. FORCE only exists when starvation protection is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // One buffered long-latency result.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lu_entry_t;

endpackage

// File: rtl/regs_wr_arbiter_if.sv
// Bundle of WB, LU, decode and register-file port signals around the arbiter.
// master: the surrounding pipeline; slave: the arbiter itself.
interface regs_wr_arbiter_if;
  import regs_arb_pkg::*;

  logic                  wb_wen_i;
  logic [REG_ADDR_W-1:0] wb_addr_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  wb_hold_o;

  logic                  lu_issue_i;
  logic [REG_ADDR_W-1:0] lu_issue_rd_i;
  logic                  lu_valid_i;
  logic                  lu_ready_o;
  logic [REG_ADDR_W-1:0] lu_rd_i;
  logic [XLEN-1:0]       lu_data_i;

  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_stall_o;

  logic                  reg_wen_o;
  logic [REG_ADDR_W-1:0] reg_addr_o;
  logic [XLEN-1:0]       reg_data_o;

  modport master (
    output wb_wen_i, wb_addr_i, wb_data_i,
    output lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
    output id_rs1_i, id_rs2_i, id_rd_i,
    input  wb_hold_o, lu_ready_o, id_stall_o,
    input  reg_wen_o, reg_addr_o, reg_data_o
  );

  modport slave (
    input  wb_wen_i, wb_addr_i, wb_data_i,
    input  lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  id_rs1_i, id_rs2_i, id_rd_i,
    output wb_hold_o, lu_ready_o, id_stall_o,
    output reg_wen_o, reg_addr_o, reg_data_o
  );

endinterface

// File: rtl/regs_arb_fifo.sv
// Small synchronous FIFO buffering LU results. The head is read combinationally
// so an entry pushed at one edge can reach the register file in the next cycle;
// with only a few entries a register array suits this better than block RAM.
module regs_arb_fifo
  import regs_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  lu_entry_t              push_data_i,
  input  logic                   pop_i,
  output lu_entry_t              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lu_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == FULL_CNT);
  assign do_push = push_i && !full_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; a push into a full FIFO is refused even if a pop happens.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset discards all buffered entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Register-file write-port arbiter between write-back and the long-latency unit,
// with a busy scoreboard for outstanding LU destinations.
// Build option: define REGS_ARB_STARVE_EN to add the LU starvation counter and
// the one-cycle FORCE state that holds WB; without it WB has strict priority.
module regs_wr_arbiter
  import regs_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               rst,
  regs_wr_arbiter_if.slave  bus
);

  localparam int FAW = $clog2(FIFO_DEPTH);

  logic            wb_active;
  logic            lu_push;
  logic            head_wr;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FAW:0]    fifo_count;
  lu_entry_t       head;
  lu_entry_t       push_entry;
  logic [XLEN-1:0] busy_q, busy_d;

  // x0 writes from WB never need the port.
  assign wb_active  = bus.wb_wen_i && (bus.wb_addr_i != '0);
  assign lu_push    = bus.lu_valid_i && !fifo_full;
  assign push_entry = '{rd: bus.lu_rd_i, data: bus.lu_data_i};

  regs_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (lu_push),
    .push_data_i (push_entry),
    .pop_i       (head_wr),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef REGS_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_cycle;
  logic             fifo_nonempty_next;

  assign force_cycle = (state_q == FORCE);
  assign head_wr     = !fifo_empty && (!wb_active || force_cycle);
  assign bus.wb_hold_o = rst && force_cycle;

  // Whether anything is still buffered after this cycle's pop/push.
  assign fifo_nonempty_next = lu_push || (|fifo_count[FAW:1]) || (!fifo_empty && !head_wr);

  // Starvation FSM: count cycles the head is passed over, then steal one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (lu_push) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (head_wr) begin
          cnt_d   = '0;
          state_d = fifo_nonempty_next ? WAIT : IDLE;
        end else if (cnt_q + CNT_W'(1) == CNT_LAST) begin
          cnt_d   = CNT_LAST;
          state_d = FORCE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FORCE: begin
        cnt_d   = '0;
        state_d = fifo_nonempty_next ? WAIT : IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // WB strictly first; LU results drain only in WB-idle cycles.
  logic unused_starve;
  assign unused_starve = ^{fifo_count, 32'(STARVE_MAX)};
  assign head_wr       = !fifo_empty && !wb_active;
  assign bus.wb_hold_o = 1'b0;
`endif

  assign bus.lu_ready_o = rst && !fifo_full;
  assign bus.id_stall_o = rst && (busy_q[bus.id_rs1_i] | busy_q[bus.id_rs2_i] | busy_q[bus.id_rd_i]);

  // Scoreboard update: retire clears, issue sets, and set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (head_wr) busy_d[head.rd] = 1'b0;
    if (bus.lu_issue_i) busy_d[bus.lu_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Write-port mux; LU results to x0 are consumed without a write.
  always_comb begin
    bus.reg_wen_o  = 1'b0;
    bus.reg_addr_o = '0;
    bus.reg_data_o = '0;
    if (!rst) begin
      bus.reg_wen_o = 1'b0;
    end else if (head_wr) begin
      bus.reg_wen_o  = (head.rd != '0);
      bus.reg_addr_o = head.rd;
      bus.reg_data_o = head.data;
    end else if (wb_active) begin
      bus.reg_wen_o  = 1'b1;
      bus.reg_addr_o = bus.wb_addr_i;
      bus.reg_data_o = bus.wb_data_i;
    end
  end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Bench for regs_wr_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_regs_wr_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  regs_wr_arbiter_if bus ();

  regs_wr_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  ent_t q[$];
  bit   busy_m[32];
  int   starve_cnt = 0;
  bit   force_now  = 1'b0;

  // Values observed in the most recent cycle.
  logic        obs_wen, obs_hold, obs_ready, obs_stall;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;

  int first_hold, holds;
  logic [4:0] hold_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.wb_wen_i      = 1'b0;
    bus.wb_addr_i     = '0;
    bus.wb_data_i     = '0;
    bus.lu_issue_i    = 1'b0;
    bus.lu_issue_rd_i = '0;
    bus.lu_valid_i    = 1'b0;
    bus.lu_rd_i       = '0;
    bus.lu_data_i     = '0;
    bus.id_rs1_i      = '0;
    bus.id_rs2_i      = '0;
    bus.id_rd_i       = '0;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    starve_cnt = 0;
    force_now  = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; check mid-cycle, then advance model.
  task automatic cycle();
    bit          wb_act, full, head_w, had, e_wen, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    wb_act = bus.wb_wen_i && (bus.wb_addr_i != 5'd0);
    full   = (q.size() == DEPTH);
    had    = (q.size() != 0);
    head_w = had && (!wb_act || force_now);
    e_wen  = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (head_w) begin
      e_wen  = (q[0].rd != 5'd0);
      e_addr = q[0].rd;
      e_data = q[0].data;
    end else if (wb_act) begin
      e_wen  = 1'b1;
      e_addr = bus.wb_addr_i;
      e_data = bus.wb_data_i;
    end
    e_stall = busy_m[bus.id_rs1_i] | busy_m[bus.id_rs2_i] | busy_m[bus.id_rd_i];
    obs_wen   = bus.reg_wen_o;
    obs_addr  = bus.reg_addr_o;
    obs_data  = bus.reg_data_o;
    obs_hold  = bus.wb_hold_o;
    obs_ready = bus.lu_ready_o;
    obs_stall = bus.id_stall_o;
    chk("reg_wen", obs_wen, e_wen);
    if (e_wen) begin
      chk("reg_addr", obs_addr, e_addr);
      chk("reg_data", obs_data, e_data);
    end
    chk("wb_hold", obs_hold, force_now);
    chk("lu_ready", obs_ready, !full);
    chk("id_stall", obs_stall, e_stall);
    @(posedge clk);
    if (head_w) begin
      busy_m[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    if (bus.lu_issue_i) busy_m[bus.lu_issue_rd_i] = 1'b1;
    busy_m[0] = 1'b0;
    if (bus.lu_valid_i && !full) q.push_back('{rd: bus.lu_rd_i, data: bus.lu_data_i});
`ifdef REGS_ARB_STARVE_EN
    if (force_now) begin
      force_now  = 1'b0;
      starve_cnt = 0;
    end else if (had) begin
      if (head_w) starve_cnt = 0;
      else begin
        starve_cnt++;
        if (starve_cnt == STARVE_MAX) force_now = 1'b1;
      end
    end
    if (q.size() == 0) starve_cnt = 0;
`endif
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_reset();

    // Outputs held at zero while reset is asserted.
    #12;
    bus.wb_wen_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'h1;
    bus.lu_valid_i = 1'b1; bus.lu_issue_i = 1'b1; bus.lu_issue_rd_i = 5'd4; bus.id_rs1_i = 5'd4;
    #1;
    chk("rst_wen", bus.reg_wen_o, 1'b0);
    chk("rst_ready", bus.lu_ready_o, 1'b0);
    chk("rst_hold", bus.wb_hold_o, 1'b0);
    chk("rst_stall", bus.id_stall_o, 1'b0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;

    // WB-only writes, including the x0 case.
    bus.wb_wen_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'hDEADBEEF;
    cycle();
    chk("wb_wen", obs_wen, 1'b1);
    chk("wb_addr", obs_addr, 5'd5);
    chk("wb_data", obs_data, 32'hDEADBEEF);
    bus.wb_addr_i = 5'd0;
    cycle();
    chk("wb_x0", obs_wen, 1'b0);

    // LU result through an idle port, scoreboard set and release.
    idle_inputs(); bus.lu_issue_i = 1'b1; bus.lu_issue_rd_i = 5'd7;
    cycle();
    idle_inputs(); bus.id_rs1_i = 5'd7;
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd7; bus.lu_data_i = 32'h1234;
    cycle();
    chk("raw_stall", obs_stall, 1'b1);
    bus.lu_valid_i = 1'b0;
    cycle();
    chk("lu_wen", obs_wen, 1'b1);
    chk("lu_addr", obs_addr, 5'd7);
    chk("lu_data", obs_data, 32'h1234);
    chk("stall_wr", obs_stall, 1'b1);
    cycle();
    chk("stall_clr", obs_stall, 1'b0);

    // Contention: WB busy while two results fill the buffer.
    idle_inputs();
    bus.wb_wen_i = 1'b1; bus.wb_addr_i = 5'd6; bus.wb_data_i = 32'hA5A50006;
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd10; bus.lu_data_i = 32'h10;
    cycle();
    chk("ready_0", obs_ready, 1'b1);
    bus.lu_rd_i = 5'd11; bus.lu_data_i = 32'h11;
    cycle();
    chk("ready_1", obs_ready, 1'b1);
    bus.lu_rd_i = 5'd12; bus.lu_data_i = 32'h12;
    cycle();
    chk("bp_ready", obs_ready, 1'b0);
    chk("bp_wb", obs_addr, 5'd6);
    bus.wb_wen_i = 1'b0; bus.lu_valid_i = 1'b0;
    cycle();
    chk("drain0", obs_addr, 5'd10);
    cycle();
    chk("drain1", obs_addr, 5'd11);
    cycle();
    chk("drained", obs_wen, 1'b0);

    // Starvation: WB active every cycle with one queued result.
    idle_inputs();
    bus.wb_wen_i = 1'b1; bus.wb_addr_i = 5'd6; bus.wb_data_i = 32'h66;
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd20; bus.lu_data_i = 32'h2020;
    cycle();
    bus.lu_valid_i = 1'b0;
    first_hold = -1; holds = 0; hold_addr = '0;
    for (int i = 0; i < STARVE_MAX + 4; i++) begin
      cycle();
      if (obs_hold === 1'b1) begin
        holds++;
        if (first_hold < 0) begin
          first_hold = i;
          hold_addr  = obs_addr;
        end
      end
    end
`ifdef REGS_ARB_STARVE_EN
    chk("starve_at", first_hold, STARVE_MAX);
    chk("starve_cnt", holds, 1);
    chk("starve_addr", hold_addr, 5'd20);
`else
    chk("no_hold", holds, 0);
    bus.wb_wen_i = 1'b0;
    cycle();
    chk("late_addr", obs_addr, 5'd20);
`endif
    idle_inputs();
    cycle();

    // Issue and retire of the same destination in one cycle: set wins.
    idle_inputs(); bus.lu_issue_i = 1'b1; bus.lu_issue_rd_i = 5'd3;
    cycle();
    idle_inputs(); bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd3; bus.lu_data_i = 32'h33;
    cycle();
    idle_inputs(); bus.lu_issue_i = 1'b1; bus.lu_issue_rd_i = 5'd3; bus.id_rs2_i = 5'd3;
    cycle();
    chk("sim_wen", obs_wen, 1'b1);
    chk("sim_addr", obs_addr, 5'd3);
    idle_inputs(); bus.id_rs2_i = 5'd3;
    cycle();
    chk("sim_stall", obs_stall, 1'b1);

    // Random traffic against the model.
    repeat (600) begin
      bus.wb_wen_i      = ($urandom_range(0, 3) != 0);
      bus.wb_addr_i     = 5'($urandom_range(0, 31));
      bus.wb_data_i     = $urandom;
      bus.lu_issue_i    = ($urandom_range(0, 3) == 0);
      bus.lu_issue_rd_i = 5'($urandom_range(0, 31));
      bus.lu_valid_i    = ($urandom_range(0, 2) == 0);
      bus.lu_rd_i       = 5'($urandom_range(0, 31));
      bus.lu_data_i     = $urandom;
      bus.id_rs1_i      = 5'($urandom_range(0, 31));
      bus.id_rs2_i      = 5'($urandom_range(0, 31));
      bus.id_rd_i       = 5'($urandom_range(0, 31));
      cycle();
    end

    // Asynchronous reset with a full buffer and busy[9] set.
    idle_inputs();
    repeat (4) cycle();
    bus.wb_wen_i = 1'b1; bus.wb_addr_i = 5'd5; bus.wb_data_i = 32'h55;
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd9; bus.lu_data_i = 32'h99;
    bus.lu_issue_i = 1'b1; bus.lu_issue_rd_i = 5'd9;
    cycle();
    bus.lu_issue_i = 1'b0; bus.lu_rd_i = 5'd13; bus.lu_data_i = 32'hD;
    cycle();
    bus.lu_valid_i = 1'b0; bus.id_rs1_i = 5'd9;
    #1;
    chk("pre_stall", bus.id_stall_o, 1'b1);
    chk("pre_wen", bus.reg_wen_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("ar_wen", bus.reg_wen_o, 1'b0);
    chk("ar_addr", bus.reg_addr_o, 5'd0);
    chk("ar_data", bus.reg_data_o, 32'd0);
    chk("ar_ready", bus.lu_ready_o, 1'b0);
    chk("ar_hold", bus.wb_hold_o, 1'b0);
    chk("ar_stall", bus.id_stall_o, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs(); bus.id_rs1_i = 5'd9;
    cycle();
    chk("post_stall", obs_stall, 1'b0);
    chk("post_ready", obs_ready, 1'b1);
    chk("post_wen", obs_wen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs_wr_arbiter.md
# regs_wr_arbiter

Shares the single write port of the 32×32 general register file between the pipeline write-back stage and the long-latency unit (LU: divider, non-blocking load returns). It also keeps a per-register busy scoreboard for outstanding LU results, so decode stalls instead of reading stale operands or reordering writes. It sits between WB/LU and the register-file write port.

## Interface
Parameters:
- FIFO_DEPTH, 2, LU result buffer entries (power of two, ≥2)
- STARVE_MAX, 8, cycles an LU result may wait before it forces the port

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- wb_wen_i  in  1  WB write request
- wb_addr_i  in  5  WB destination
- wb_data_i  in  32  WB data
- wb_hold_o  out  1  freeze WB stage this cycle (WB write not performed)
- lu_issue_i  in  1  LU op issued from decode this cycle
- lu_issue_rd_i  in  5  its destination
- lu_valid_i  in  1  LU result valid
- lu_ready_o  out  1  arbiter accepts LU result
- lu_rd_i  in  5  LU result destination
- lu_data_i  in  32  LU result data
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  decode operand/destination addresses
- id_stall_o  out  1  decode must stall
- reg_wen_o  out  1  register-file write enable
- reg_addr_o  out  5  register-file write address
- reg_data_o  out  32  register-file write data

## Operation
- LU results are pushed into the FIFO on lu_valid_i && lu_ready_o. lu_ready_o = !full; no pass-through when full, even if a pop occurs in the same cycle.
- A WB write is "active" when wb_wen_i && wb_addr_i≠0. WB address 0 never uses the port.
- Port grant: WB wins by default. The FIFO head is written when WB is not active, or when the FSM is in FORCE.
- Pop occurs on every head write.
- FSM:
  - IDLE: FIFO empty.
  - WAIT: FIFO non-empty. The wait counter increments on each cycle the head is not written. It clears on a head write and on entering IDLE.
  - WAIT→FORCE when the counter reaches STARVE_MAX.
  - FORCE: head is written, wb_hold_o=1, WB write masked. Lasts exactly 1 cycle, then WAIT if entries remain, else IDLE.
- Scoreboard busy[31:1]; busy[0] is hardwired 0.
  - lu_issue_i with rd≠0 sets busy[rd].
  - A head write clears busy[head rd].
  - Set and clear of the same rd in one cycle: set wins.
- id_stall_o = busy[rs1] | busy[rs2] | busy[rd]. This covers RAW and WAW.
- LU results with rd=0 are popped without asserting reg_wen_o.

## Timing
- reg_wen_o, reg_addr_o, reg_data_o, wb_hold_o and id_stall_o are combinational from the inputs and registered state. The register file's read bypass covers same-cycle consumers.
- WB write latency: 0 cycles.
- LU latency: a result accepted at edge N is written no earlier than cycle N+1.
- busy clears at the edge ending the write cycle; id_stall_o for that register falls 1 cycle after the write.
- Worst-case LU wait is STARVE_MAX+1 cycles (only when REGS_ARB_STARVE_EN is defined).
- Reset (rst=0, asynchronous):
  - FIFO emptied, busy cleared, counter=0, FSM=IDLE.
  - All outputs forced to 0, including lu_ready_o.
  - An in-flight write is dropped.

## Configuration
- REGS_ARB_STARVE_EN defined: WAIT counter, FORCE state and wb_hold_o behave as above.
- REGS_ARB_STARVE_EN undefined:
  - WB has strict priority; no counter and no FORCE state.
  - wb_hold_o is tied to 0.
  - LU results may wait indefinitely.

## Structure
- Package regs_arb_pkg: arb_state_t enum (IDLE, WAIT, FORCE), REG_ADDR_W=5, XLEN=32, and the LU result entry struct {rd, data}.
- One sub-module: regs_arb_fifo (parameterised sync FIFO with full/empty flags). Scoreboard, FSM and port mux live in the top.

## Test plan
- WB only: wb_wen_i=1, addr=5, data=0xDEADBEEF → same cycle reg_wen_o=1, addr=5, data=0xDEADBEEF; wb_wen_i=1 with addr=0 → reg_wen_o=0.
- LU idle port: issue rd=7 → id_stall_o=1 for rs1=7. Push 0x1234 with WB idle → written next cycle, then id_stall_o=0 the following cycle.
- Contention and backpressure: WB active continuously while 2 LU results are pushed → lu_ready_o=0 after the 2nd push; FIFO drains in order on the first WB-idle cycles.
- Starvation (macro on, STARVE_MAX=8): WB active every cycle, 1 LU entry queued → wb_hold_o=1 for exactly 1 cycle, 8 cycles after entering WAIT; the LU write occurs that cycle.
- Simultaneous issue and retire of rd=3 in one cycle → busy[3] remains 1; id_stall_o stays 1 for rs2=3.
- Asynchronous reset asserted with 2 FIFO entries and busy[9]=1 → all outputs 0 immediately; after release, FIFO is empty and id_stall_o=0 for rs1=9.
